id_stage_fwd: RTL and testbench

- Parametrised decode stage with a registered ID/EX output and a valid/ready handshake on both sides.
- Decodes the MIPS subset, resolves operands through an N-port forwarding network, and detects load-use hazards, stalling with bubble insertion.
- Resolves branches and jumps in ID and tracks delay slots.
- Sits between the IF/ID register and the EX stage; operand reads go to the dual-read register file.

---
 rtl/id_stage_fwd.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_id_stage_fwd.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_fwd.sv
// MIPS-subset decode stage with forwarding, load-use stall, branch resolution in ID and a
// registered ID/EX output. Define ID_PERF_CNT_EN to add stall/bubble cycle counters.
module id_stage_fwd #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_PORTS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [31:0]                   in_addr_i,
  input  logic [31:0]                   in_inst_i,
  output logic                          rf_r1_en_o,
  output logic                          rf_r2_en_o,
  output logic [REG_AW-1:0]             rf_r1_addr_o,
  output logic [REG_AW-1:0]             rf_r2_addr_o,
  input  logic [DATA_W-1:0]             rf_r1_data_i,
  input  logic [DATA_W-1:0]             rf_r2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_en_i,
  input  logic [FWD_PORTS*REG_AW-1:0]   fwd_addr_i,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_is_load_i,
  input  logic                          flush_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [7:0]                    out_alu_o,
  output logic [DATA_W-1:0]             out_oprd1_o,
  output logic [DATA_W-1:0]             out_oprd2_o,
  output logic                          out_wreg_en_o,
  output logic [REG_AW-1:0]             out_wreg_addr_o,
  output logic [31:0]                   out_link_addr_o,
  output logic                          out_in_delayslot_o,
  output logic                          out_illegal_o,
  output logic                          jump_en_o,
  output logic [31:0]                   jump_target_o,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]                   stall_cycles_o,
  output logic [31:0]                   bubble_cycles_o,
`endif
  output logic                          stall_req_o
);

  // ALU code: [7:5] result class, [4:0] operation within the class.
  localparam logic [7:0] AluNop    = 8'h00;
  localparam logic [7:0] AluAnd    = 8'h20;
  localparam logic [7:0] AluOr     = 8'h21;
  localparam logic [7:0] AluXor    = 8'h22;
  localparam logic [7:0] AluNor    = 8'h23;
  localparam logic [7:0] AluLui    = 8'h24;
  localparam logic [7:0] AluSll    = 8'h40;
  localparam logic [7:0] AluSrl    = 8'h41;
  localparam logic [7:0] AluSra    = 8'h42;
  localparam logic [7:0] AluMfhi   = 8'h60;
  localparam logic [7:0] AluMflo   = 8'h61;
  localparam logic [7:0] AluMthi   = 8'h62;
  localparam logic [7:0] AluMtlo   = 8'h63;
  localparam logic [7:0] AluMovn   = 8'h64;
  localparam logic [7:0] AluMovz   = 8'h65;
  localparam logic [7:0] AluAddu   = 8'h80;
  localparam logic [7:0] AluLb     = 8'hA0;
  localparam logic [7:0] AluLw     = 8'hA1;
  localparam logic [7:0] AluLink   = 8'hC0;
  localparam logic [7:0] AluJump   = 8'hC1;
  localparam logic [7:0] AluBranch = 8'hC2;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] index;

  assign op    = in_inst_i[31:26];
  assign rs    = in_inst_i[25:21];
  assign rt    = in_inst_i[20:16];
  assign rd    = in_inst_i[15:11];
  assign shamt = in_inst_i[10:6];
  assign funct = in_inst_i[5:0];
  assign imm   = in_inst_i[15:0];
  assign index = in_inst_i[25:0];

  logic [DATA_W-1:0] imm_z, imm_s, imm_lui, shamt_z;
  assign imm_z   = DATA_W'(imm);
  assign imm_s   = DATA_W'($signed(imm));
  assign imm_lui = DATA_W'({imm, 16'h0000});
  assign shamt_z = DATA_W'(shamt);

  logic [7:0]        alu_c;
  logic              r1_en_c, r2_en_c, wen_c, illegal_c;
  logic [DATA_W-1:0] imm1_c, imm2_c;
  logic [REG_AW-1:0] waddr_c;
  logic              is_beq, is_bne, is_blez, is_bgtz, is_j, is_jr, is_movn, is_movz;

  always_comb begin
    alu_c     = AluNop;
    r1_en_c   = 1'b0;
    r2_en_c   = 1'b0;
    imm1_c    = '0;
    imm2_c    = '0;
    wen_c     = 1'b0;
    waddr_c   = '0;
    illegal_c = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_blez   = 1'b0;
    is_bgtz   = 1'b0;
    is_j      = 1'b0;
    is_jr     = 1'b0;
    is_movn   = 1'b0;
    is_movz   = 1'b0;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h00, 6'h02, 6'h03: begin
            alu_c   = (funct == 6'h00) ? AluSll : (funct == 6'h02) ? AluSrl : AluSra;
            r2_en_c = 1'b1;
            imm1_c  = shamt_z;
            wen_c   = 1'b1;
            waddr_c = REG_AW'(rd);
          end
          6'h04, 6'h06, 6'h07: begin
            alu_c   = (funct == 6'h04) ? AluSll : (funct == 6'h06) ? AluSrl : AluSra;
            r1_en_c = 1'b1;
            r2_en_c = 1'b1;
            wen_c   = 1'b1;
            waddr_c = REG_AW'(rd);
          end
          6'h08: begin
            alu_c   = AluJump;
            r1_en_c = 1'b1;
            is_jr   = 1'b1;
          end
          6'h09: begin
            alu_c   = AluLink;
            r1_en_c = 1'b1;
            is_jr   = 1'b1;
            wen_c   = 1'b1;
            waddr_c = REG_AW'(rd);
          end
          6'h0A, 6'h0B: begin
            alu_c   = (funct == 6'h0A) ? AluMovz : AluMovn;
            r1_en_c = 1'b1;
            r2_en_c = 1'b1;
            is_movz = (funct == 6'h0A);
            is_movn = (funct == 6'h0B);
            waddr_c = REG_AW'(rd);
          end
          6'h0F: ;
          6'h10, 6'h12: begin
            alu_c   = (funct == 6'h10) ? AluMfhi : AluMflo;
            wen_c   = 1'b1;
            waddr_c = REG_AW'(rd);
          end
          6'h11, 6'h13: begin
            alu_c   = (funct == 6'h11) ? AluMthi : AluMtlo;
            r1_en_c = 1'b1;
          end
          6'h24, 6'h25, 6'h26, 6'h27: begin
            alu_c   = (funct == 6'h24) ? AluAnd : (funct == 6'h25) ? AluOr :
                      (funct == 6'h26) ? AluXor : AluNor;
            r1_en_c = 1'b1;
            r2_en_c = 1'b1;
            wen_c   = 1'b1;
            waddr_c = REG_AW'(rd);
          end
          default: illegal_c = 1'b1;
        endcase
      end
      6'h02: begin
        alu_c = AluJump;
        is_j  = 1'b1;
      end
      6'h03: begin
        alu_c   = AluLink;
        is_j    = 1'b1;
        wen_c   = 1'b1;
        waddr_c = REG_AW'(31);
      end
      6'h04, 6'h05: begin
        alu_c   = AluBranch;
        r1_en_c = 1'b1;
        r2_en_c = 1'b1;
        is_beq  = (op == 6'h04);
        is_bne  = (op == 6'h05);
      end
      6'h06, 6'h07: begin
        alu_c   = AluBranch;
        r1_en_c = 1'b1;
        is_blez = (op == 6'h06);
        is_bgtz = (op == 6'h07);
      end
      6'h09, 6'h20, 6'h23: begin
        alu_c   = (op == 6'h09) ? AluAddu : (op == 6'h20) ? AluLb : AluLw;
        r1_en_c = 1'b1;
        imm2_c  = imm_s;
        wen_c   = 1'b1;
        waddr_c = REG_AW'(rt);
      end
      6'h0C, 6'h0D, 6'h0E: begin
        alu_c   = (op == 6'h0C) ? AluAnd : (op == 6'h0D) ? AluOr : AluXor;
        r1_en_c = 1'b1;
        imm2_c  = imm_z;
        wen_c   = 1'b1;
        waddr_c = REG_AW'(rt);
      end
      6'h0F: begin
        alu_c   = AluLui;
        imm2_c  = imm_lui;
        wen_c   = 1'b1;
        waddr_c = REG_AW'(rt);
      end
      6'h33: ;
      default: illegal_c = 1'b1;
    endcase
  end

  // Operand resolution: the lowest-index matching port wins; a load there means the value
  // does not exist yet, so the stage must stall.
  logic [1:0][REG_AW-1:0] src_addr;
  logic [1:0][DATA_W-1:0] src_rf, src_val;
  logic [1:0]             src_en, src_haz;

  assign src_addr = {REG_AW'(rt), REG_AW'(rs)};
  assign src_rf   = {rf_r2_data_i, rf_r1_data_i};
  assign src_en   = {r2_en_c, r1_en_c};

  always_comb begin
    src_val = src_rf;
    src_haz = '0;
    for (int s = 0; s < 2; s++) begin
      for (int p = int'(FWD_PORTS) - 1; p >= 0; p--) begin
        if (fwd_en_i[p] && (fwd_addr_i[p*REG_AW +: REG_AW] == src_addr[s])) begin
          src_val[s] = fwd_data_i[p*DATA_W +: DATA_W];
          src_haz[s] = fwd_is_load_i[p];
        end
      end
      if (src_addr[s] == '0) begin
        src_val[s] = '0;
        src_haz[s] = 1'b0;
      end
      if (!src_en[s]) src_haz[s] = 1'b0;
    end
  end

  logic [DATA_W-1:0] oprd1, oprd2;
  logic              wen_final;
  assign oprd1     = r1_en_c ? src_val[0] : imm1_c;
  assign oprd2     = r2_en_c ? src_val[1] : imm2_c;
  assign wen_final = is_movn ? (oprd2 != '0) : is_movz ? (oprd2 == '0) : wen_c;

  logic hazard, advance, fire;
  logic out_valid_q;
  assign hazard  = in_valid_i && (|src_haz);
  assign advance = !out_valid_q || out_ready_i;
  assign fire    = in_valid_i && !hazard && !flush_i && advance;

  assign in_ready_o   = fire;
  assign stall_req_o  = hazard;
  assign rf_r1_en_o   = in_valid_i && r1_en_c;
  assign rf_r2_en_o   = in_valid_i && r2_en_c;
  assign rf_r1_addr_o = REG_AW'(rs);
  assign rf_r2_addr_o = REG_AW'(rt);

  logic [31:0] pc4, br_target, link_addr;
  logic        taken, is_ctrl;
  assign pc4       = in_addr_i + 32'd4;
  assign link_addr = in_addr_i + 32'd8;
  assign br_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign is_ctrl   = is_beq || is_bne || is_blez || is_bgtz || is_j || is_jr;

  always_comb begin
    taken = 1'b0;
    if (is_beq)  taken = (oprd1 == oprd2);
    if (is_bne)  taken = (oprd1 != oprd2);
    if (is_bgtz) taken = !oprd1[DATA_W-1] && (|oprd1);
    if (is_blez) taken = oprd1[DATA_W-1] || (oprd1 == '0);
    if (is_j || is_jr) taken = 1'b1;
  end

  assign jump_en_o     = fire && taken;
  assign jump_target_o = is_j  ? {pc4[31:28], index, 2'b00} :
                         is_jr ? 32'(oprd1) : br_target;

  logic [7:0]        alu_q;
  logic [DATA_W-1:0] oprd1_q, oprd2_q;
  logic              wen_q, ds_out_q, illegal_q, ds_q;
  logic [REG_AW-1:0] waddr_q;
  logic [31:0]       link_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      oprd1_q     <= '0;
      oprd2_q     <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      link_q      <= '0;
      ds_out_q    <= 1'b0;
      illegal_q   <= 1'b0;
      ds_q        <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      ds_q        <= 1'b0;
    end else begin
      if (advance) begin
        out_valid_q <= fire;
        if (fire) begin
          alu_q     <= alu_c;
          oprd1_q   <= oprd1;
          oprd2_q   <= oprd2;
          wen_q     <= wen_final;
          waddr_q   <= waddr_c;
          link_q    <= link_addr;
          ds_out_q  <= ds_q;
          illegal_q <= illegal_c;
        end
      end
      // Set by every branch/jump (taken or not), consumed by the next fired instruction.
      if (fire) ds_q <= is_ctrl;
    end
  end

  assign out_valid_o        = out_valid_q;
  assign out_alu_o          = alu_q;
  assign out_oprd1_o        = oprd1_q;
  assign out_oprd2_o        = oprd2_q;
  assign out_wreg_en_o      = wen_q;
  assign out_wreg_addr_o    = waddr_q;
  assign out_link_addr_o    = link_q;
  assign out_in_delayslot_o = ds_out_q;
  assign out_illegal_o      = illegal_q;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hazard) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i || (advance && !fire)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o  = stall_cnt_q;
  assign bubble_cycles_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed self-checking bench for id_stage_fwd: forwarding, load-use stall, branches,
// delay slots, backpressure, flush, illegal decode and mid-stall reset.
module tb_id_stage_fwd;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned FP = 2;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   in_addr, in_inst;
  logic          rf_r1_en, rf_r2_en;
  logic [AW-1:0] rf_r1_addr, rf_r2_addr;
  logic [DW-1:0] rf_r1_data, rf_r2_data;
  logic [FP-1:0] fwd_en, fwd_is_load;
  logic [FP*AW-1:0] fwd_addr;
  logic [FP*DW-1:0] fwd_data;
  logic [7:0]    out_alu;
  logic [DW-1:0] out_oprd1, out_oprd2;
  logic          out_wreg_en, out_in_delayslot, out_illegal, jump_en, stall_req;
  logic [AW-1:0] out_wreg_addr;
  logic [31:0]   out_link_addr, jump_target;
`ifdef ID_PERF_CNT_EN
  logic [31:0]   stall_cycles, bubble_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register-file model: register n reads as 0x1000_0000 | n.
  assign rf_r1_data = 32'h1000_0000 | {27'h0, rf_r1_addr};
  assign rf_r2_data = 32'h1000_0000 | {27'h0, rf_r2_addr};

  id_stage_fwd #(.DATA_W(DW), .REG_AW(AW), .FWD_PORTS(FP)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_addr_i          (in_addr),
    .in_inst_i          (in_inst),
    .rf_r1_en_o         (rf_r1_en),
    .rf_r2_en_o         (rf_r2_en),
    .rf_r1_addr_o       (rf_r1_addr),
    .rf_r2_addr_o       (rf_r2_addr),
    .rf_r1_data_i       (rf_r1_data),
    .rf_r2_data_i       (rf_r2_data),
    .fwd_en_i           (fwd_en),
    .fwd_addr_i         (fwd_addr),
    .fwd_data_i         (fwd_data),
    .fwd_is_load_i      (fwd_is_load),
    .flush_i            (flush),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_alu_o          (out_alu),
    .out_oprd1_o        (out_oprd1),
    .out_oprd2_o        (out_oprd2),
    .out_wreg_en_o      (out_wreg_en),
    .out_wreg_addr_o    (out_wreg_addr),
    .out_link_addr_o    (out_link_addr),
    .out_in_delayslot_o (out_in_delayslot),
    .out_illegal_o      (out_illegal),
    .jump_en_o          (jump_en),
    .jump_target_o      (jump_target),
`ifdef ID_PERF_CNT_EN
    .stall_cycles_o     (stall_cycles),
    .bubble_cycles_o    (bubble_cycles),
`endif
    .stall_req_o        (stall_req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] inst);
    in_valid = 1'b1;
    in_addr  = addr;
    in_inst  = inst;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_wreg_en !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", out_wreg_en); end
    checks++; if (out_oprd1 !== 32'h0) begin errors++; $display("FAIL reset_oprd1 got %h want 0", out_oprd1); end
    checks++; if (out_in_delayslot !== 1'b0) begin errors++; $display("FAIL reset_ds got %b want 0", out_in_delayslot); end
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL reset_jump got %b want 0", jump_en); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_priority();
    fwd_en = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'h5555, 32'hAAAA}; fwd_is_load = 2'b00;
    issue(32'h0000_0000, 32'h3421_00FF);  // ORI r1,r1,0x00FF
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; fwd_en = '0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %b want 1", out_valid); end
    checks++; if (out_oprd1 !== 32'hAAAA) begin errors++; $display("FAIL fwd_oprd1 got %h want 0000aaaa", out_oprd1); end
    checks++; if (out_oprd2 !== 32'h0000_00FF) begin errors++; $display("FAIL fwd_oprd2 got %h want 000000ff", out_oprd2); end
    checks++; if ({out_wreg_en, out_wreg_addr} !== {1'b1, 5'd1}) begin errors++; $display("FAIL fwd_wreg got %b/%0d want 1/1", out_wreg_en, out_wreg_addr); end
    checks++; if (out_alu !== 8'h21) begin errors++; $display("FAIL fwd_alu got %h want 21", out_alu); end
  endtask

  task automatic test_load_use();
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd2}; fwd_data = '0; fwd_is_load = 2'b01;
    issue(32'h0000_0004, 32'h0022_1824);  // AND r3,r1,r2
    for (int c = 0; c < 2; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready[%0d] got %b want 0", c, in_ready); end
      checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lu_stall[%0d] got %b want 1", c, stall_req); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble[%0d] got %b want 0", c, out_valid); end
    end
    fwd_en = '0; fwd_is_load = '0;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", stall_req); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_issue got %b want 1", out_valid); end
    checks++; if (out_oprd1 !== 32'h1000_0001) begin errors++; $display("FAIL lu_oprd1 got %h want 10000001", out_oprd1); end
    checks++; if (out_oprd2 !== 32'h1000_0002) begin errors++; $display("FAIL lu_oprd2 got %h want 10000002", out_oprd2); end
    checks++; if (out_wreg_addr !== 5'd3) begin errors++; $display("FAIL lu_waddr got %0d want 3", out_wreg_addr); end
  endtask

  task automatic test_branch_ds();
    issue(32'h0000_0100, 32'h10A5_0004);  // BEQ r5,r5,+4
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL beq_jump got %b want 1", jump_en); end
    checks++; if (jump_target !== 32'h0000_0114) begin errors++; $display("FAIL beq_target got %h want 00000114", jump_target); end
    tick();
    checks++; if (out_in_delayslot !== 1'b0) begin errors++; $display("FAIL beq_ds got %b want 0", out_in_delayslot); end
    issue(32'h0000_0104, 32'h3406_0001);  // ORI r6,r0,1 in the slot
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL slot_jump got %b want 0", jump_en); end
    tick();
    checks++; if (out_in_delayslot !== 1'b1) begin errors++; $display("FAIL slot_ds got %b want 1", out_in_delayslot); end
    issue(32'h0000_0108, 32'h14A5_0004);  // BNE r5,r5 not taken
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL bne_jump got %b want 0", jump_en); end
    tick();
    checks++; if (out_in_delayslot !== 1'b0) begin errors++; $display("FAIL bne_ds got %b want 0", out_in_delayslot); end
    issue(32'h0000_010C, 32'h3406_0001);
    tick();
    checks++; if (out_in_delayslot !== 1'b1) begin errors++; $display("FAIL bne_slot_ds got %b want 1", out_in_delayslot); end
    issue(32'h0000_0110, 32'h3406_0001);
    tick();
    in_valid = 1'b0;
    checks++; if (out_in_delayslot !== 1'b0) begin errors++; $display("FAIL after_slot_ds got %b want 0", out_in_delayslot); end
  endtask

  task automatic test_jal();
    issue(32'h0040_0000, 32'h0C10_0010);  // JAL
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL jal_jump got %b want 1", jump_en); end
    checks++; if (jump_target !== 32'h0040_0040) begin errors++; $display("FAIL jal_target got %h want 00400040", jump_target); end
    tick();
    checks++; if ({out_wreg_en, out_wreg_addr} !== {1'b1, 5'd31}) begin errors++; $display("FAIL jal_wreg got %b/%0d want 1/31", out_wreg_en, out_wreg_addr); end
    checks++; if (out_link_addr !== 32'h0040_0008) begin errors++; $display("FAIL jal_link got %h want 00400008", out_link_addr); end
    issue(32'h0040_0004, 32'h0000_000F);  // SYNC in the slot
    tick();
    in_valid = 1'b0;
    checks++; if (out_in_delayslot !== 1'b1) begin errors++; $display("FAIL sync_ds got %b want 1", out_in_delayslot); end
    checks++; if (out_wreg_en !== 1'b0) begin errors++; $display("FAIL sync_wen got %b want 0", out_wreg_en); end
  endtask

  task automatic test_backpressure_flush();
    issue(32'h0000_0200, 32'h0800_0080);  // J 0x200
    tick();
    out_ready = 1'b0;
    issue(32'h0000_0204, 32'h3407_1234);  // ORI r7,r0,0x1234
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_link_addr !== 32'h0000_0208) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h want 1/00000208", c, out_valid, out_link_addr); end
      tick();
    end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_in_delayslot !== 1'b0) begin errors++; $display("FAIL flush_ds got %b want 0", out_in_delayslot); end
    checks++; if (out_oprd2 !== 32'h0000_1234 || out_wreg_addr !== 5'd7) begin errors++; $display("FAIL flush_next got %h/%0d want 00001234/7", out_oprd2, out_wreg_addr); end
  endtask

  task automatic test_illegal_r0();
    issue(32'h0000_0300, 32'hFC00_0000);
    tick();
    checks++; if ({out_valid, out_illegal, out_wreg_en} !== 3'b110) begin errors++; $display("FAIL ill_flags got %b want 110", {out_valid, out_illegal, out_wreg_en}); end
    checks++; if (out_alu !== 8'h00) begin errors++; $display("FAIL ill_alu got %h want 00", out_alu); end
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFFFF}; fwd_is_load = '0;
    issue(32'h0000_0304, 32'h0000_2025);  // OR r4,r0,r0
    tick();
    in_valid = 1'b0; fwd_en = '0;
    checks++; if (out_oprd1 !== 32'h0 || out_oprd2 !== 32'h0) begin errors++; $display("FAIL r0_oprd got %h/%h want 0/0", out_oprd1, out_oprd2); end
    checks++; if (out_illegal !== 1'b0 || out_wreg_addr !== 5'd4) begin errors++; $display("FAIL r0_dec got %b/%0d want 0/4", out_illegal, out_wreg_addr); end
  endtask

  task automatic test_movn_movz();
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd2}; fwd_data = '0; fwd_is_load = '0;
    issue(32'h0000_0400, 32'h0022_400B);  // MOVN r8,r1,r2 with r2 forwarded as 0
    tick();
    checks++; if (out_wreg_en !== 1'b0) begin errors++; $display("FAIL movn_wen got %b want 0", out_wreg_en); end
    checks++; if (out_oprd1 !== 32'h1000_0001) begin errors++; $display("FAIL movn_oprd1 got %h want 10000001", out_oprd1); end
    issue(32'h0000_0404, 32'h0022_400A);  // MOVZ r8,r1,r2
    tick();
    in_valid = 1'b0; fwd_en = '0;
    checks++; if ({out_wreg_en, out_wreg_addr} !== {1'b1, 5'd8}) begin errors++; $display("FAIL movz_wreg got %b/%0d want 1/8", out_wreg_en, out_wreg_addr); end
  endtask

  task automatic test_reset_mid_stall();
    issue(32'h0000_0500, 32'h3406_0001);
    tick();
    out_ready = 1'b0;
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd2}; fwd_is_load = 2'b01;
    issue(32'h0000_0504, 32'h0022_1824);
    checks++; if (stall_req !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rms_pre got %b/%b want 1/1", stall_req, out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; fwd_en = '0; fwd_is_load = '0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_wreg_en !== 1'b0) begin errors++; $display("FAIL rms_post got %b/%b want 0/0", out_valid, out_wreg_en); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b1;
    fwd_en = '0; fwd_addr = '0; fwd_data = '0; fwd_is_load = '0;
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_branch_ds();
    test_jal();
    test_backpressure_flush();
    test_illegal_r0();
    test_movn_movz();
    test_reset_mid_stall();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
